debug_unit_ctrl: RTL and testbench

- Parametrised command controller of the debug unit. Sits between the UART rx/tx byte interfaces, the program memory write port and the pipeline.
- Single self-contained FSM with three modes:
  - LOAD: assembles program words from rx bytes and writes them to program memory.
  - RUN: free-runs the pipe until it halts or times out.
  - STEP: advances the pipe one cycle per command.
- After RUN and after each step it latches a snapshot {cycle count, pipe data} and streams it out byte by byte.

---
 rtl/debug_unit_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_debug_unit_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit_ctrl.sv
// debug_unit_ctrl
// Command controller for the debug unit. It decodes command bytes from the
// UART receiver and runs in one of three modes:
//   LOAD - assembles program words from rx bytes and writes them to
//          program memory.
//   RUN  - free-runs the pipe until it halts or times out.
//   STEP - advances the pipe one cycle per command.
// After a RUN and after each step, it latches a snapshot frame
// {cycle count, pipe data} and transmits it least-significant byte first.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   i_rx_data/is_rx_done  received byte and its 1-cycle valid pulse
//   is_tx_done          transmitter finished the current byte
//   i_data_from_pipe    pipeline debug state (PIPE_W bits)
//   is_stop_pipe        pipe has executed halt (level)
//   o_step              pipe clock enable
//   o_pipe_rst_n        0 holds the pipe in reset
//   o_address/o_instruction/os_MemWrite  program memory write port
//   o_tx_data/os_tx_start  byte to transmit and its 1-cycle start pulse
//   o_led               1 while idle
//
// state        | meaning
// S_IDLE       | waiting for a command byte, pipe held in reset
// S_LOAD       | collecting bytes of one program word
// S_LOAD_WR    | memory write strobe active, then advance the address
// S_RUN        | pipe free-running, one step per cycle
// S_STEP_WAIT  | step mode, waiting for a step or exit command
// S_STEP_GO    | single step pulse active
// S_SEND_LATCH | capture the snapshot frame
// S_SEND_START | present the next byte with a start pulse
// S_SEND_WAIT  | wait for the transmitter to finish that byte
module debug_unit_ctrl #(
  parameter int                 PIPE_W     = 2558,
  parameter int                 CNT_W      = 32,
  parameter int                 INSTR_W    = 32,
  parameter int                 ADDR_W     = 8,
  parameter logic [INSTR_W-1:0] HALT_WORD  = INSTR_W'(32'hFFFF_FFFF),
  parameter int                 MAX_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          i_rx_data,
  input  logic                is_rx_done,
  input  logic                is_tx_done,
  input  logic [PIPE_W-1:0]   i_data_from_pipe,
  input  logic                is_stop_pipe,
  output logic                o_step,
  output logic                o_pipe_rst_n,
  output logic [ADDR_W-1:0]   o_address,
  output logic [INSTR_W-1:0]  o_instruction,
  output logic                os_MemWrite,
  output logic [7:0]          o_tx_data,
  output logic                os_tx_start,
  output logic                o_led
);

  localparam int FRAME_W = ((CNT_W + PIPE_W + 7) / 8) * 8;
  localparam int NB      = FRAME_W / 8;
  localparam int NBW     = $clog2(NB + 1);
  localparam int BPW     = INSTR_W / 8;
  localparam int BCW     = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_LOAD_WR, S_RUN, S_STEP_WAIT,
    S_STEP_GO, S_SEND_LATCH, S_SEND_START, S_SEND_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic                 ret_step_q, ret_step_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [BCW-1:0]       bcnt_q, bcnt_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [NBW-1:0]       bidx_q, bidx_d;
  logic                 step_q, step_d;
  logic                 we_q, we_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 pipe_rst_n_q, pipe_rst_n_d;
  logic                 led_q, led_d;

  // Counter saturates rather than wrapping.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    ret_step_d = ret_step_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    bcnt_d     = bcnt_q;
    frame_d    = frame_q;
    bidx_d     = bidx_q;
    tx_data_d  = tx_data_q;
    step_d     = 1'b0;
    we_d       = 1'b0;
    tx_start_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_rx_done) begin
          case (i_rx_data)
            8'h01: begin state_d = S_LOAD; addr_d = '0; bcnt_d = '0; end
            8'h02: begin state_d = S_RUN; cnt_d = '0; ret_step_d = 1'b0; end
            8'h03: begin state_d = S_STEP_WAIT; cnt_d = '0; ret_step_d = 1'b1; end
            default: ;
          endcase
        end
      end
      S_LOAD: begin
        if (is_rx_done) begin
          // Bytes arrive MSB first, so shift toward the top.
          instr_d = (instr_q << 8) | INSTR_W'(i_rx_data);
          if (bcnt_q == BCW'(BPW - 1)) begin
            bcnt_d  = '0;
            we_d    = 1'b1;
            state_d = S_LOAD_WR;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      S_LOAD_WR: begin
        // Address and data stay put during the strobe; the last address
        // ends the load instead of wrapping.
        if (instr_q == HALT_WORD || addr_q == '1) begin
          state_d = S_IDLE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        if (is_stop_pipe || cnt_q == CNT_W'(MAX_CYCLES)) begin
          state_d = S_SEND_LATCH;
        end else begin
          step_d = 1'b1;
          cnt_d  = cnt_inc;
        end
      end
      S_STEP_WAIT: begin
        if (is_rx_done) begin
          if (i_rx_data == 8'h04) begin
            if (is_stop_pipe) begin
              state_d = S_SEND_LATCH;
            end else begin
              step_d  = 1'b1;
              cnt_d   = cnt_inc;
              state_d = S_STEP_GO;
            end
          end else if (i_rx_data == 8'h05) begin
            state_d = S_IDLE;
          end
        end
      end
      // Let the step land in the pipe before the snapshot is taken.
      S_STEP_GO: state_d = S_SEND_LATCH;
      S_SEND_LATCH: begin
        frame_d = FRAME_W'({cnt_q, i_data_from_pipe});
        bidx_d  = '0;
        state_d = S_SEND_START;
      end
      S_SEND_START: begin
        tx_start_d = 1'b1;
        tx_data_d  = frame_q[7:0];
        frame_d    = frame_q >> 8;
        state_d    = S_SEND_WAIT;
      end
      S_SEND_WAIT: begin
        // A done coincident with our own start belongs to the previous byte.
        if (is_tx_done && !tx_start_q) begin
          if (bidx_q == NBW'(NB - 1)) begin
            state_d = ret_step_q ? S_STEP_WAIT : S_IDLE;
          end else begin
            bidx_d  = bidx_q + 1'b1;
            state_d = S_SEND_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    pipe_rst_n_d = !(state_d inside {S_IDLE, S_LOAD, S_LOAD_WR});
    led_d        = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ret_step_q   <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      instr_q      <= '0;
      bcnt_q       <= '0;
      frame_q      <= '0;
      bidx_q       <= '0;
      step_q       <= 1'b0;
      we_q         <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      pipe_rst_n_q <= 1'b0;
      led_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      ret_step_q   <= ret_step_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      bcnt_q       <= bcnt_d;
      frame_q      <= frame_d;
      bidx_q       <= bidx_d;
      step_q       <= step_d;
      we_q         <= we_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      pipe_rst_n_q <= pipe_rst_n_d;
      led_q        <= led_d;
    end
  end

  assign o_step        = step_q;
  assign o_pipe_rst_n  = pipe_rst_n_q;
  assign o_address     = addr_q;
  assign o_instruction = instr_q;
  assign os_MemWrite   = we_q;
  assign o_tx_data     = tx_data_q;
  assign os_tx_start   = tx_start_q;
  assign o_led         = led_q;

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Directed bench for debug_unit_ctrl: load, run (halt and timeout), step,
// ignored commands and reset in the middle of a frame transfer.
module tb_debug_unit_ctrl;
  localparam int PIPE_W  = 2558;
  localparam int CNT_W   = 32;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 8;
  localparam int NB      = 324;
  localparam int FRAME_W = NB * 8;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [7:0]          i_rx_data = 8'h00;
  logic                is_rx_done = 1'b0;
  logic                is_tx_done = 1'b0;
  logic [PIPE_W-1:0]   pipe = '0;
  logic                is_stop_pipe = 1'b0;
  logic                o_step, o_pipe_rst_n, os_MemWrite, os_tx_start, o_led;
  logic [ADDR_W-1:0]   o_address;
  logic [INSTR_W-1:0]  o_instruction;
  logic [7:0]          o_tx_data;

  debug_unit_ctrl #(.MAX_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .i_rx_data(i_rx_data), .is_rx_done(is_rx_done),
    .is_tx_done(is_tx_done), .i_data_from_pipe(pipe), .is_stop_pipe(is_stop_pipe),
    .o_step(o_step), .o_pipe_rst_n(o_pipe_rst_n), .o_address(o_address),
    .o_instruction(o_instruction), .os_MemWrite(os_MemWrite),
    .o_tx_data(o_tx_data), .os_tx_start(os_tx_start), .o_led(o_led)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Environment model: pipe halt, memory write capture, transmitter.
  int                 steps = 0;
  int                 stop_at = 0;
  bit                 stop_en = 1'b0;
  bit                 force_stop = 1'b0;
  int                 proto_err = 0;
  bit                 busy = 1'b0;
  int                 ctr = 0;
  logic [7:0]         tx_q[$];
  logic [ADDR_W-1:0]  wr_addr[$];
  logic [INSTR_W-1:0] wr_data[$];

  always @(negedge clk) begin
    is_tx_done = 1'b0;
    if (o_step) steps++;
    if (os_MemWrite) begin
      wr_addr.push_back(o_address);
      wr_data.push_back(o_instruction);
    end
    if (os_tx_start) begin
      if (busy) proto_err++;
      busy = 1'b1;
      ctr  = 2;
      // Spurious done in the start cycle on some bytes; must be ignored.
      if (tx_q.size() % 7 == 3) is_tx_done = 1'b1;
      tx_q.push_back(o_tx_data);
    end else if (busy) begin
      if (ctr == 0) begin
        is_tx_done = 1'b1;
        busy = 1'b0;
      end else begin
        ctr--;
      end
    end
    is_stop_pipe = force_stop || (stop_en && steps >= stop_at);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rx(input logic [7:0] b);
    @(negedge clk);
    i_rx_data  = b;
    is_rx_done = 1'b1;
    @(negedge clk);
    is_rx_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (o_led !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, o_led, 1'b1);
  endtask

  task automatic wait_tx(input string tag, input int target, input int bound);
    int n = 0;
    while (tx_q.size() < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (tx_q.size() >= target), 1'b1);
  endtask

  // Rebuild the received frame and compare it with {pad, cnt, pipe}.
  task automatic check_frame(input string tag, input int base, input logic [31:0] c);
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int i = 0; i < NB; i++) begin
      if (base + i < tx_q.size()) f[8*i +: 8] = tx_q[base + i];
      else f[8*i +: 8] = 8'hxx;
    end
    chk({tag, "_byte0"}, f[7:0], pipe[7:0]);
    chk({tag, "_cnt"}, f[PIPE_W +: CNT_W], c);
    chk({tag, "_pad"}, f[FRAME_W-1 -: 2], 2'b00);
    chk({tag, "_pipe"}, (f[PIPE_W-1:0] === pipe), 1'b1);
  endtask

  initial begin
    int b, s0, wb, n_after;
    for (int k = 0; k < PIPE_W; k++) pipe[k] = 1'($urandom_range(0, 1));
    pipe[7:0] = 8'hA5;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_led", o_led, 1'b1);
    chk("rst_pipe_rst_n", o_pipe_rst_n, 1'b0);
    chk("rst_step", o_step, 1'b0);
    chk("rst_memwrite", os_MemWrite, 1'b0);
    chk("rst_tx_start", os_tx_start, 1'b0);
    chk("rst_address", o_address, 0);
    chk("rst_instruction", o_instruction, 0);
    chk("rst_tx_data", o_tx_data, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Load two words, the second is the halt word
    wb = wr_addr.size();
    rx(8'h01);
    chk("load_led_busy", o_led, 1'b0);
    rx(8'h00); rx(8'h00); rx(8'h00); rx(8'h2A);
    rx(8'hFF); rx(8'hFF); rx(8'hFF); rx(8'hFF);
    repeat (3) @(negedge clk);
    chk("load_nwrites", wr_addr.size() - wb, 2);
    chk("load_addr0", wr_addr[wb], 0);
    chk("load_data0", wr_data[wb], 32'h0000_002A);
    chk("load_addr1", wr_addr[wb+1], 1);
    chk("load_data1", wr_data[wb+1], 32'hFFFF_FFFF);
    chk("load_idle", o_led, 1'b1);

    // Load without a halt word: stops after the top address, no wrap
    wb = wr_addr.size();
    rx(8'h01);
    for (int w = 0; w < 256; w++) begin
      rx(8'h00); rx(8'h00); rx(8'h00); rx(w[7:0]);
    end
    repeat (3) @(negedge clk);
    chk("load256_nwrites", wr_addr.size() - wb, 256);
    chk("load256_first_addr", wr_addr[wb], 0);
    chk("load256_last_addr", wr_addr[wb+255], 8'hFF);
    chk("load256_last_data", wr_data[wb+255], 32'h0000_00FF);
    chk("load256_idle", o_led, 1'b1);

    // Run until the pipe halts after 10 steps
    stop_en = 1'b1; stop_at = steps + 10;
    s0 = steps; b = tx_q.size();
    rx(8'h02);
    chk("run_pipe_out_of_rst", o_pipe_rst_n, 1'b1);
    wait_idle("run_halt_idle", 8000);
    chk("run_halt_steps", steps - s0, 10);
    chk("run_halt_nbytes", tx_q.size() - b, NB);
    check_frame("run_halt", b, 32'd10);
    chk("run_halt_pipe_rst", o_pipe_rst_n, 1'b0);

    // Run with a pipe that never halts: MAX_CYCLES timeout
    stop_en = 1'b0;
    for (int k = 0; k < PIPE_W; k++) pipe[k] = 1'($urandom_range(0, 1));
    pipe[7:0] = 8'h3C;
    s0 = steps; b = tx_q.size();
    rx(8'h02);
    wait_idle("run_to_idle", 8000);
    chk("run_to_steps", steps - s0, 16);
    chk("run_to_nbytes", tx_q.size() - b, NB);
    check_frame("run_to", b, 32'd16);

    // Step mode
    rx(8'h03);
    chk("stepw_led", o_led, 1'b0);
    chk("stepw_pipe_rst_n", o_pipe_rst_n, 1'b1);
    s0 = steps; b = tx_q.size();
    rx(8'h04);
    wait_tx("step1_tx_wait", b + NB, 4000);
    repeat (8) @(negedge clk);
    chk("step1_steps", steps - s0, 1);
    check_frame("step1", b, 32'd1);
    s0 = steps; b = tx_q.size();
    rx(8'h04);
    wait_tx("step2_tx_wait", b + NB, 4000);
    repeat (8) @(negedge clk);
    chk("step2_steps", steps - s0, 1);
    check_frame("step2", b, 32'd2);
    force_stop = 1'b1;
    s0 = steps; b = tx_q.size();
    rx(8'h04);
    wait_tx("step3_tx_wait", b + NB, 4000);
    repeat (8) @(negedge clk);
    chk("step_halted_steps", steps - s0, 0);
    check_frame("step_halted", b, 32'd2);
    force_stop = 1'b0;

    // 0x01 in step mode is ignored
    s0 = steps; b = tx_q.size(); wb = wr_addr.size();
    rx(8'h01);
    repeat (4) @(negedge clk);
    chk("stepw_ign_steps", steps - s0, 0);
    chk("stepw_ign_tx", tx_q.size() - b, 0);
    chk("stepw_ign_wr", wr_addr.size() - wb, 0);
    chk("stepw_ign_led", o_led, 1'b0);
    rx(8'h05);
    chk("step_exit_led", o_led, 1'b1);
    chk("step_exit_pipe_rst", o_pipe_rst_n, 1'b0);

    // Unknown byte in IDLE is ignored
    s0 = steps; b = tx_q.size(); wb = wr_addr.size();
    rx(8'h7E);
    repeat (4) @(negedge clk);
    chk("idle_ign_steps", steps - s0, 0);
    chk("idle_ign_tx", tx_q.size() - b, 0);
    chk("idle_ign_wr", wr_addr.size() - wb, 0);
    chk("idle_ign_led", o_led, 1'b1);
    chk("idle_ign_pipe_rst", o_pipe_rst_n, 1'b0);

    // Reset during byte 100 of a frame
    stop_en = 1'b1; stop_at = steps + 5;
    b = tx_q.size();
    rx(8'h02);
    wait_tx("rst_mid_tx_wait", b + 100, 8000);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst_mid_led", o_led, 1'b1);
    chk("rst_mid_tx_start", os_tx_start, 1'b0);
    chk("rst_mid_tx_data", o_tx_data, 0);
    chk("rst_mid_pipe_rst", o_pipe_rst_n, 1'b0);
    n_after = tx_q.size();
    chk("rst_mid_bytes_sent", n_after - b, 100);
    repeat (60) @(negedge clk);
    chk("rst_mid_no_more_tx", tx_q.size(), n_after);
    chk("rst_mid_proto", proto_err, 0);
    stop_at = steps + 3;
    b = tx_q.size();
    rx(8'h02);
    wait_idle("rst_rerun_idle", 8000);
    chk("rst_rerun_nbytes", tx_q.size() - b, NB);
    check_frame("rst_rerun", b, 32'd3);

    chk("tx_protocol", proto_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
